fast_square_rx_framer: RTL and testbench

//  Sink for the fast-square baseband comb output stream. Consumes {i,q} samples qualified by a strobe
//  (one per 16 clocks). Locks onto the 16'h8000/16'h8000 restart marker that the comb block emits

---
 rtl/fast_square_rx_framer_pkg.sv | 18 +
 rtl/fast_square_rx_framer_if.sv | 16 +
 rtl/fast_square_word_emitter.sv | 81 ++++++++
 rtl/fast_square_rx_framer.sv | 136 +++++++++++++
 tb/tb_fast_square_rx_framer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fast_square_rx_framer_pkg.sv
// Shared types and constants for the fast-square RX framer.
package fast_square_rx_framer_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [15:0] MARKER_WORD   = 16'h8000;
    localparam logic [15:0] DEF_HDR_MAGIC = 16'hA5A5;

    // Restart marker: both halves of the pair carry the marker word.
    function automatic logic is_marker(input logic [15:0] i, input logic [15:0] q);
        return (i == MARKER_WORD) && (q == MARKER_WORD);
    endfunction

endpackage

// File: rtl/fast_square_rx_framer_if.sv
// Sample input stream and FIFO write port of the RX framer.
interface fast_square_rx_framer_if;
    logic        data_in_strobe;
    logic [15:0] i_in;
    logic [15:0] q_in;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        wr_full;

    // Environment side: comb chain feeding samples, FIFO reporting full.
    modport master (output data_in_strobe, i_in, q_in, wr_full,
                    input  wr_data, wr_en);
    // Framer side.
    modport slave  (input  data_in_strobe, i_in, q_in, wr_full,
                    output wr_data, wr_en);
endinterface

// File: rtl/fast_square_word_emitter.sv
// One-entry pair buffer plus word sequencer: HDR, count, I, Q (or just I, Q).
// The current word sits in a register; wr_en is that word's valid gated by
// wr_full so a write is never issued into a full FIFO.
module fast_square_word_emitter
    import fast_square_rx_framer_pkg::*;
#(
    parameter logic [15:0] HDR_MAGIC = DEF_HDR_MAGIC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        load_hdr,
    input  logic        load_last,
    input  logic [15:0] load_i,
    input  logic [15:0] load_q,
    input  logic        abort,
    input  logic [15:0] frame_count,
    input  logic        wr_full,
    output logic [15:0] wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        frame_done
);

    logic        occ;
    logic [1:0]  idx;      // 0 hdr, 1 count, 2 I, 3 Q
    logic [15:0] buf_i;
    logic [15:0] buf_q;
    logic [15:0] data_q;
    logic        last_q;
    logic        stop_q;
    logic        write;
    logic        stop;
    logic        fin;

    assign write      = occ && !wr_full;
    assign stop       = abort || stop_q;
    // An I already on the bus is always followed by its Q, even when stopping.
    assign fin        = write && ((idx == 2'd3) || (stop && idx != 2'd2));
    // The entry frees as its final word leaves, so a sample may load that cycle.
    assign busy       = occ && !fin;
    assign frame_done = write && (idx == 2'd3) && last_q && !stop;
    assign wr_en      = write;
    assign wr_data    = data_q;

    // Load a new pair, or advance through its words as the FIFO accepts them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ    <= 1'b0;
            idx    <= 2'd0;
            buf_i  <= '0;
            buf_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            if (load) begin
                occ    <= 1'b1;
                buf_i  <= load_i;
                buf_q  <= load_q;
                last_q <= load_last;
                stop_q <= 1'b0;
                idx    <= load_hdr ? 2'd0 : 2'd2;
                data_q <= load_hdr ? HDR_MAGIC : load_i;
            end else if (fin) begin
                occ    <= 1'b0;
                stop_q <= 1'b0;
            end else if (write) begin
                idx <= idx + 2'd1;
                case (idx)
                    2'd0:    data_q <= frame_count;
                    2'd1:    data_q <= buf_i;
                    default: data_q <= buf_q;
                endcase
            end
            if (abort && busy)
                stop_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fast_square_rx_framer.sv
// RX framer: locks on the comb restart marker, then frames sample pairs
// into header-prefixed word runs for the host RX FIFO.
module fast_square_rx_framer
    import fast_square_rx_framer_pkg::*;
#(
    parameter int          FRAME_LEN   = 256,
    parameter int          MIN_MARKERS = 16,
    parameter logic [15:0] HDR_MAGIC   = DEF_HDR_MAGIC
) (
    input  logic                          clock,
    input  logic                          reset,
    fast_square_rx_framer_if.slave        bus,
    input  logic                          clear_overrun,
    output logic                          sync_locked,
    output logic                          overrun,
    output logic [15:0]                   drop_count,
    output logic [15:0]                   frame_count
);

    localparam int SCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int MCW = $clog2(MIN_MARKERS + 1);

    state_t           state;
    logic [MCW-1:0]   mcount;
    logic [SCW-1:0]   scnt;
    logic             hdr_pend;   // sample 0 was dropped; next accepted sample carries the header
    logic             marker;
    logic             sample;
    logic             accept_evt;
    logic             abort;
    logic             first;
    logic             last;
    logic             busy;
    logic             load;
    logic             drop;
    logic             frame_done;

    assign marker     = bus.data_in_strobe && is_marker(bus.i_in, bus.q_in);
    assign sample     = bus.data_in_strobe && !marker;
    assign accept_evt = sample && (state != HUNT);
    assign abort      = marker && (state == STREAM);
    assign first      = (scnt == '0);
    assign last       = (scnt == SCW'(FRAME_LEN - 1));
    assign load       = accept_evt && !busy;
    assign drop       = accept_evt && busy;

    fast_square_word_emitter #(.HDR_MAGIC(HDR_MAGIC)) u_emit (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_hdr    (first || hdr_pend),
        .load_last   (last),
        .load_i      (bus.i_in),
        .load_q      (bus.q_in),
        .abort       (abort),
        .frame_count (frame_count),
        .wr_full     (bus.wr_full),
        .wr_data     (bus.wr_data),
        .wr_en       (bus.wr_en),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Lock FSM with the sample position counter and deferred-header flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            mcount      <= '0;
            scnt        <= '0;
            hdr_pend    <= 1'b0;
            sync_locked <= 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    if (marker) begin
                        mcount <= mcount + 1'b1;
                        if (int'(mcount) + 1 >= MIN_MARKERS) begin
                            state       <= ARMED;
                            sync_locked <= 1'b1;
                        end
                    end else if (sample) begin
                        mcount <= '0;
                    end
                end
                ARMED: begin
                    if (sample)
                        state <= STREAM;
                end
                STREAM: begin
                    if (marker) begin
                        state       <= HUNT;
                        mcount      <= MCW'(1);
                        scnt        <= '0;
                        hdr_pend    <= 1'b0;
                        sync_locked <= 1'b0;
                    end
                end
                default: begin
                    state       <= HUNT;
                    sync_locked <= 1'b0;
                end
            endcase
            if (accept_evt) begin
                scnt <= last ? '0 : scnt + 1'b1;
                if (last || load)
                    hdr_pend <= 1'b0;
                else if (first)
                    hdr_pend <= 1'b1;
            end
        end
    end

    // Drop/overrun status and completed-frame counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            drop_count  <= '0;
            frame_count <= '0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
                if (clear_overrun)
                    drop_count <= 16'd1;
                else if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end else if (clear_overrun) begin
                overrun    <= 1'b0;
                drop_count <= '0;
            end
            // A dropped final sample closes its frame at the wrap.
            if (frame_done || (drop && last))
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fast_square_rx_framer.sv
// Scoreboard bench for fast_square_rx_framer (FRAME_LEN=4, MIN_MARKERS=16).
module tb_fast_square_rx_framer;

    localparam int          FL    = 4;
    localparam int          MIN_M = 16;
    localparam logic [15:0] HDR   = 16'hA5A5;

    logic        clock;
    logic        reset;
    logic        clear_overrun;
    logic        sync_locked;
    logic        overrun;
    logic [15:0] drop_count;
    logic [15:0] frame_count;

    fast_square_rx_framer_if bus();

    fast_square_rx_framer #(.FRAME_LEN(FL), .MIN_MARKERS(MIN_M), .HDR_MAGIC(HDR)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .clear_overrun (clear_overrun),
        .sync_locked   (sync_locked),
        .overrun       (overrun),
        .drop_count    (drop_count),
        .frame_count   (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // Reference model: spec rules in terms of counts and a word queue.
    int m_run, m_pos, m_fc, m_rem, m_drops;
    bit m_locked, m_streaming, m_hdr_owed, m_ovr;
    int full_left = 0;
    bit rnd_full  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_fc = 0; m_rem = 0; m_drops = 0;
        m_locked = 0; m_streaming = 0; m_hdr_owed = 0; m_ovr = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit stb, input logic [15:0] i, input logic [15:0] q,
                              input bit full, input bit clr);
        bit drop = 0;
        if (m_rem > 0 && !full) m_rem--;
        if (stb) begin
            if (i == 16'h8000 && q == 16'h8000) begin
                if (!m_locked) begin
                    m_run++;
                    if (m_run >= MIN_M) m_locked = 1;
                end else if (m_streaming) begin
                    m_locked = 0; m_streaming = 0; m_run = 1; m_pos = 0; m_hdr_owed = 0;
                end
            end else if (!m_locked) begin
                m_run = 0;
            end else begin
                m_streaming = 1;
                if (m_rem > 0) begin
                    drop = 1;
                    if (m_pos == 0) m_hdr_owed = 1;
                end else begin
                    if (m_pos == 0 || m_hdr_owed) begin
                        exp_q.push_back(HDR);
                        exp_q.push_back(16'(m_fc));
                        m_rem = 2;
                        m_hdr_owed = 0;
                    end
                    exp_q.push_back(i);
                    exp_q.push_back(q);
                    m_rem += 2;
                end
                if (m_pos == FL - 1) begin
                    m_fc = (m_fc + 1) % 65536; m_pos = 0; m_hdr_owed = 0;
                end else begin
                    m_pos++;
                end
            end
        end
        if (drop) begin
            m_ovr = 1;
            m_drops = clr ? 1 : (m_drops < 65535 ? m_drops + 1 : 65535);
        end else if (clr) begin
            m_ovr = 0; m_drops = 0;
        end
    endtask

    task automatic cyc(input bit stb, input logic [15:0] i, input logic [15:0] q, input bit clr);
        bit full;
        if (full_left > 0) begin
            full = 1; full_left--;
        end else begin
            full = rnd_full && ($urandom_range(0, 3) == 0);
        end
        bus.data_in_strobe = stb; bus.i_in = i; bus.q_in = q;
        bus.wr_full = full; clear_overrun = clr;
        model_step(stb, i, q, full, clr);
        @(posedge clock); #1;
    endtask

    task automatic slot(input logic [15:0] i, input logic [15:0] q, input bit clr);
        cyc(1, i, q, clr);
        for (int k = 0; k < 15; k++) cyc(0, 16'($urandom), 16'($urandom), 0);
    endtask

    task automatic mark_slot();
        slot(16'h8000, 16'h8000, 0);
    endtask

    task automatic samp_slot(input bit clr);
        logic [15:0] i, q;
        i = 16'($urandom_range(0, 16'h7FFF)); q = 16'($urandom);
        slot(i, q, clr);
    endtask

    task automatic drain(input string name);
        int n = 0;
        rnd_full = 0; full_left = 0;
        while (m_rem > 0 && n < 200) begin cyc(0, 16'h0, 16'h0, 0); n++; end
        cyc(0, 16'h0, 16'h0, 0); cyc(0, 16'h0, 16'h0, 0);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic status(input string name);
        chk({name, "_sync_locked"}, int'(sync_locked), int'(m_locked));
        chk({name, "_overrun"},     int'(overrun),     int'(m_ovr));
        chk({name, "_drop_count"},  int'(drop_count),  m_drops);
        chk({name, "_frame_count"}, int'(frame_count), m_fc);
    endtask

    // Monitor: every accepted FIFO write must match the next expected word.
    always @(negedge clock) begin
        if (!reset && bus.wr_en) begin
            checks++;
            if (bus.wr_full) begin
                errors++;
                $display("FAIL wr_en_while_full: wr_en %0b wr_full %0b required wr_en 0", bus.wr_en, bus.wr_full);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %0h expected no write", bus.wr_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.wr_data !== e) begin
                    errors++;
                    $display("FAIL word: got %0h expected %0h", bus.wr_data, e);
                end
            end
        end
    end

    initial begin
        reset = 1; clear_overrun = 0;
        bus.data_in_strobe = 0; bus.i_in = 0; bus.q_in = 0; bus.wr_full = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wr_en", int'(bus.wr_en), 0);
        status("rst");
        reset = 0;

        // Lock after 16 markers, first sample carries header with count 0.
        for (int k = 0; k < 15; k++) mark_slot();
        chk("t1_unlocked_15", int'(sync_locked), 0);
        mark_slot();
        chk("t1_locked_16", int'(sync_locked), 1);
        slot(16'h0001, 16'h0002, 0);
        chk("t1_streamed_words", exp_q.size(), 0);

        // Eight more samples: two full frames then a third header.
        for (int k = 0; k < 8; k++) samp_slot(0);
        drain("t3");
        status("t3");
        chk("t3_two_frames", int'(frame_count), 2);

        // FIFO full 40 cycles from a strobe: next two samples drop.
        full_left = 40;
        for (int k = 0; k < 4; k++) samp_slot(0);
        drain("t4");
        status("t4");
        chk("t4_two_drops", int'(drop_count), 2);
        // Clear coinciding with a drop: drop wins.
        full_left = 20;
        samp_slot(0);
        samp_slot(1);
        drain("t4c");
        status("t4c");
        cyc(0, 16'h0, 16'h0, 1);
        status("t4clr");

        // Marker mid-frame at sample 2 aborts; relock after 15 more.
        while (m_pos != 2) samp_slot(0);
        mark_slot();
        status("t5_abort");
        for (int k = 0; k < 14; k++) mark_slot();
        chk("t5_unlocked_14", int'(sync_locked), 0);
        mark_slot();
        chk("t5_relocked", int'(sync_locked), 1);
        samp_slot(0);
        drain("t5");
        status("t5");

        // Randomized traffic with stalls, occasional markers and clears.
        for (int n = 0; n < 90; n++) begin
            rnd_full = 1;
            if ($urandom_range(0, 99) < 15) full_left = $urandom_range(10, 40);
            if (!m_locked && $urandom_range(0, 99) < 85) mark_slot();
            else if (m_locked && m_rem == 0 && $urandom_range(0, 99) < 5) mark_slot();
            else samp_slot($urandom_range(0, 19) == 0);
        end
        drain("rand");
        status("rand");

        // Async reset in the middle of a 4-word sequence.
        while (!m_locked) mark_slot();
        while (m_pos != 0) samp_slot(0);
        drain("t6pre");
        cyc(1, 16'h1234, 16'h5678, 0);
        cyc(0, 16'h0, 16'h0, 0);
        #2 reset = 1;
        #1;
        chk("t6_wr_en_async", int'(bus.wr_en), 0);
        model_reset();
        status("t6");
        @(posedge clock); #1;
        reset = 0;

        // 15 markers, a sample, 16 markers: lock only on the 32nd strobe.
        for (int k = 0; k < 15; k++) mark_slot();
        samp_slot(0);
        for (int k = 0; k < 15; k++) mark_slot();
        chk("t2_unlocked_31", int'(sync_locked), 0);
        mark_slot();
        chk("t2_locked_32", int'(sync_locked), 1);
        drain("t2");
        status("t2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
